// File: rtl/maneuver_sequencer_pkg.sv
// Shared encodings for the speech-mode maneuver sequencer: motor modes, voice
// command bytes, FSM states and the command decoder.
package maneuver_sequencer_pkg;

    localparam logic [2:0] MODE_STOP  = 3'b000;
    localparam logic [2:0] MODE_RIGHT = 3'b001;
    localparam logic [2:0] MODE_LEFT  = 3'b010;
    localparam logic [2:0] MODE_FWD   = 3'b011;
    localparam logic [2:0] MODE_BACK  = 3'b100;

    localparam logic [7:0] CMD_FWD   = 8'd111;
    localparam logic [7:0] CMD_BACK  = 8'd251;
    localparam logic [7:0] CMD_LEFT  = 8'd247;
    localparam logic [7:0] CMD_RIGHT = 8'd186;
    localparam logic [7:0] CMD_UTURN = 8'd183;
    localparam logic [7:0] CMD_ROT_L = 8'd105;
    localparam logic [7:0] CMD_ROT_R = 8'd217;

    typedef enum logic [1:0] {ST_IDLE, ST_CONT, ST_TIMED, ST_HOLD} state_e;
    typedef enum logic [1:0] {DUR_TURN, DUR_UTURN, DUR_ROT} dur_sel_e;

    typedef struct packed {
        state_e     state;
        logic [2:0] mode;
        dur_sel_e   dur;
    } cmd_decode_t;

    // Anything that is not a known maneuver decodes to a stop.
    function automatic cmd_decode_t decode_cmd(input logic [7:0] code);
        cmd_decode_t d;
        d.state = ST_IDLE;
        d.mode  = MODE_STOP;
        d.dur   = DUR_TURN;
        case (code)
            CMD_FWD:   begin d.state = ST_CONT;  d.mode = MODE_FWD;   end
            CMD_BACK:  begin d.state = ST_CONT;  d.mode = MODE_BACK;  end
            CMD_LEFT:  begin d.state = ST_TIMED; d.mode = MODE_LEFT;  end
            CMD_RIGHT: begin d.state = ST_TIMED; d.mode = MODE_RIGHT; end
            CMD_UTURN: begin d.state = ST_TIMED; d.mode = MODE_LEFT;  d.dur = DUR_UTURN; end
            CMD_ROT_L: begin d.state = ST_TIMED; d.mode = MODE_LEFT;  d.dur = DUR_ROT;   end
            CMD_ROT_R: begin d.state = ST_TIMED; d.mode = MODE_RIGHT; d.dur = DUR_ROT;   end
            default:   ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/maneuver_sequencer_timer.sv
// Counts active cycles of a timed maneuver; holds its count while paused and
// flags the last active cycle so the sequencer can finish on that edge.
module pausable_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         run,
    input  logic         pause,
    input  logic [W-1:0] target,
    output logic         expire
);

    logic [W-1:0] count;

    assign expire = run && !pause && (count == target - 1'b1);

    // NOTE: registers take <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run && !pause) begin
            count <= expire ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/maneuver_sequencer.sv
// Speech-mode maneuver sequencer: decodes voice commands, runs continuous or
// timed maneuvers, and overrides the motor mode around obstacles.
module maneuver_sequencer
    import maneuver_sequencer_pkg::*;
#(
    parameter int TURN_CYC  = 2**26,
    parameter int UTURN_CYC = 2**27,
    parameter int ROT_CYC   = 2**28,
    parameter int OBST_CM   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_code,
    input  logic [19:0] distance,
    input  logic        rear_block,
    output logic [2:0]  mode,
    output logic        busy,
    output logic        done,
    output logic        paused,
    output logic        alarm
);

    localparam int MAX_TU  = (UTURN_CYC > TURN_CYC) ? UTURN_CYC : TURN_CYC;
    localparam int MAX_CYC = (ROT_CYC > MAX_TU) ? ROT_CYC : MAX_TU;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    state_e         state;
    logic [2:0]     cur_dir;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] dur_cyc;
    cmd_decode_t    dec;
    logic           front_obs;
    logic           expire;

    assign dec       = decode_cmd(cmd_code);
    assign front_obs = distance < 20'(OBST_CM);

    always_comb begin
        dur_cyc = CNT_W'(TURN_CYC);
        case (dec.dur)
            DUR_UTURN: dur_cyc = CNT_W'(UTURN_CYC);
            DUR_ROT:   dur_cyc = CNT_W'(ROT_CYC);
            default:   dur_cyc = CNT_W'(TURN_CYC);
        endcase
    end

    // A command on the expiry cycle clears the timer, so it suppresses that done pulse.
    pausable_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (cmd_valid),
        .run    ((state == ST_TIMED) && !cmd_valid),
        .pause  (front_obs),
        .target (target),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_dir <= MODE_STOP;
            target  <= '0;
            mode    <= MODE_STOP;
            busy    <= 1'b0;
            done    <= 1'b0;
            paused  <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cmd_valid) begin
                state   <= dec.state;
                cur_dir <= dec.mode;
                target  <= dur_cyc;
                mode    <= dec.mode;
                busy    <= (dec.state != ST_IDLE);
                paused  <= 1'b0;
                alarm   <= 1'b0;
            end else begin
                case (state)
                    ST_CONT: begin
                        alarm <= front_obs && rear_block;
                        if (cur_dir == MODE_FWD) begin
                            paused <= front_obs;
                            mode   <= front_obs ? MODE_STOP : MODE_FWD;
                        end else begin
                            paused <= rear_block;
                            mode   <= rear_block ? MODE_STOP : MODE_BACK;
                        end
                    end
                    ST_TIMED: begin
                        if (front_obs) begin
                            // Back away from the obstacle unless the rear is blocked too.
                            paused <= 1'b1;
                            alarm  <= rear_block;
                            mode   <= rear_block ? MODE_STOP : MODE_BACK;
                        end else if (expire) begin
                            state  <= ST_HOLD;
                            mode   <= MODE_STOP;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            paused <= 1'b0;
                            alarm  <= 1'b0;
                        end else begin
                            mode   <= cur_dir;
                            paused <= 1'b0;
                            alarm  <= 1'b0;
                        end
                    end
                    default: begin
                        mode   <= MODE_STOP;
                        busy   <= 1'b0;
                        paused <= 1'b0;
                        alarm  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
